// File: rtl/gpio_scan_ctrl.sv
// GPIO scan-chain responder: shifts in a command packet, drives the SRAM test port, captures and shifts back read data.
// Optional feature macro SCAN_BITCOUNT_EN: access is refused (short_pkt) until a full packet has been shifted in.
module gpio_scan_ctrl #(
   parameter int SEL_WIDTH   = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int WMASK_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   scan_en,
   input  logic                   scan_in,
   input  logic                   sram_load,
   input  logic                   global_csb,
   input  logic [DATA_WIDTH-1:0]  dout0_i,
   input  logic [DATA_WIDTH-1:0]  dout1_i,
   output logic                   scan_out,
   output logic [SEL_WIDTH-1:0]   sram_sel,
   output logic                   csb0,
   output logic                   web0,
   output logic [WMASK_WIDTH-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0]  addr0,
   output logic [DATA_WIDTH-1:0]  din0,
   output logic                   csb1,
   output logic                   web1,
   output logic [WMASK_WIDTH-1:0] wmask1,
   output logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  din1,
   output logic                   short_pkt
);
   localparam int PKT_WIDTH = SEL_WIDTH + 2*(ADDR_WIDTH+DATA_WIDTH+2+WMASK_WIDTH);
   // Field LSB positions, MSB-first layout: sel, port 0 group, port 1 group
   localparam int SEL_LSB = PKT_WIDTH - SEL_WIDTH;
   localparam int A0_LSB  = SEL_LSB - ADDR_WIDTH;
   localparam int D0_LSB  = A0_LSB - DATA_WIDTH;
   localparam int CSB0_B  = D0_LSB - 1;
   localparam int WEB0_B  = D0_LSB - 2;
   localparam int M0_LSB  = WEB0_B - WMASK_WIDTH;
   localparam int A1_LSB  = M0_LSB - ADDR_WIDTH;
   localparam int D1_LSB  = A1_LSB - DATA_WIDTH;
   localparam int CSB1_B  = D1_LSB - 1;
   localparam int WEB1_B  = D1_LSB - 2;

   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_ACCESS, S_CAPTURE, S_LOADED} state_t;

   state_t                  state_q, state_d;
   logic [PKT_WIDTH-1:0]    pkt_q, pkt_d;
   logic [DATA_WIDTH-1:0]   dout0_q, dout0_d, dout1_q, dout1_d;
   logic                    block;

`ifdef SCAN_BITCOUNT_EN
   localparam int CNT_W = $clog2(PKT_WIDTH+1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_WIDTH);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             scan_en_q, short_q, short_d, cnt_short;

   assign cnt_short = (cnt_q < CNT_FULL);
   assign block     = scan_en | cnt_short;
   assign short_pkt = short_q;
`else
   assign block     = scan_en;
   assign short_pkt = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      dout0_d = dout0_q;
      dout1_d = dout1_q;
`ifdef SCAN_BITCOUNT_EN
      cnt_d   = cnt_q;
      short_d = short_q | (!global_csb && !scan_en && cnt_short);
      // Counter restarts with each new burst of scan_en so stale partial packets never count
      if (scan_en) cnt_d = !scan_en_q ? CNT_W'(1) : (cnt_short ? cnt_q + 1'b1 : cnt_q);
`endif
      if (scan_en) pkt_d = {pkt_q[PKT_WIDTH-2:0], scan_in};
      case (state_q)
         S_IDLE: begin
            if (scan_en) state_d = S_SHIFT;
            else if (sram_load) begin
               state_d = S_LOADED;
               pkt_d[D0_LSB +: DATA_WIDTH] = dout0_q;
               pkt_d[D1_LSB +: DATA_WIDTH] = dout1_q;
`ifdef SCAN_BITCOUNT_EN
               cnt_d = CNT_FULL;
`endif
            end
            else if (!global_csb && !block) state_d = S_ACCESS;
         end
         S_SHIFT:   if (!scan_en) state_d = S_IDLE;
         // SRAM sampled on the edge entering ACCESS; its read data is valid now
         S_ACCESS: begin
            state_d = S_CAPTURE;
            dout0_d = dout0_i;
            dout1_d = dout1_i;
         end
         S_CAPTURE: state_d = S_IDLE;
         S_LOADED:  if (scan_en) state_d = S_SHIFT;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pkt_q     <= '0;
         dout0_q   <= '0;
         dout1_q   <= '0;
`ifdef SCAN_BITCOUNT_EN
         cnt_q     <= '0;
         scan_en_q <= 1'b0;
         short_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pkt_q     <= pkt_d;
         dout0_q   <= dout0_d;
         dout1_q   <= dout1_d;
`ifdef SCAN_BITCOUNT_EN
         cnt_q     <= cnt_d;
         scan_en_q <= scan_en;
         short_q   <= short_d;
`endif
      end
   end

   assign scan_out = pkt_q[PKT_WIDTH-1];
   assign sram_sel = pkt_q[SEL_LSB +: SEL_WIDTH];
   assign addr0    = pkt_q[A0_LSB +: ADDR_WIDTH];
   assign din0     = pkt_q[D0_LSB +: DATA_WIDTH];
   assign web0     = pkt_q[WEB0_B];
   assign wmask0   = pkt_q[M0_LSB +: WMASK_WIDTH];
   assign addr1    = pkt_q[A1_LSB +: ADDR_WIDTH];
   assign din1     = pkt_q[D1_LSB +: DATA_WIDTH];
   assign web1     = pkt_q[WEB1_B];
   assign wmask1   = pkt_q[0 +: WMASK_WIDTH];
   // Chip-select is combinational in global_csb so the macro samples in the strobe cycle
   assign csb0     = pkt_q[CSB0_B] | global_csb | block | reset;
   assign csb1     = pkt_q[CSB1_B] | global_csb | block | reset;
endmodule
